cond_code_decoder: RTL
======================

Name: cond_code_decoder

Overview:
- Receiver-side decoder for the 2-bit condition codes produced by the team's condition encoder (if-, case- and ternary-style maps).
- Accepts the three redundant codes per symbol and inverts each map to recover sel, then majority-votes the results.
- Output is registered behind a valid/ready handshake; error statistics are kept and a fault lock-out is applied.
- Sits between the encoder output bus and downstream control logic.

Parameters:
- CNT_W, 8, width of the saturating corrected/error counters.
- ERR_LIMIT, 3, consecutive uncorrectable symbols that drive the FSM to FAULT (legal range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input symbol valid.
- in_ready  output  1  decoder can accept a symbol.
- code_if  input  2  if-map code; encoder map sel→sel+1 mod 4.
- code_case  input  2  case-map code; encoder map sel→sel+3 mod 4.
- code_tern  input  2  ternary-map code; encoder map sel→sel+2 mod 4.
- out_valid  output  1  decoded symbol valid.
- out_ready  input  1  downstream accepts.
- sel_out  output  2  recovered sel.
- corrected  output  1  exactly one code disagreed and was outvoted.
- uncorrectable  output  1  all three decoded values differ.
- fault  output  1  FSM is in FAULT.
- corr_cnt  output  CNT_W  saturating count of corrected symbols.
- err_cnt  output  CNT_W  saturating count of uncorrectable symbols.
- clear  input  1  synchronous clear of the counters and FAULT.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, sel_out=0, corrected=0, uncorrectable=0, fault=0, corr_cnt=0, err_cnt=0, consecutive-error count=0, FSM=RUN. in_ready goes to 1 after reset deasserts.
- Decode, all mod 4: d_if=code_if-1, d_case=code_case+1, d_tern=code_tern-2.
- Vote: if all three values are equal → that value, flags 0. If exactly two are equal → the majority value, corrected=1. If all three differ → sel_out=d_if, uncorrectable=1.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A transfer happens on in_valid && in_ready.
  - Latency is 1 cycle: the result and flags register on the accept edge and out_valid=1 the next cycle.
  - Output data and flags hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready when there is no new accept.
  - Back-to-back throughput is 1 symbol/cycle when out_ready=1.
- Counters update on accept:
  - corr_cnt increments on corrected; err_cnt increments on uncorrectable.
  - Both saturate at 2^CNT_W-1 and never wrap.
- FSM, RUN/FAULT:
  - The consecutive-error count increments on an accepted uncorrectable symbol and resets to 0 on any accepted good or corrected symbol.
  - When the count reaches ERR_LIMIT: go to FAULT, fault=1, in_ready=0.
  - A pending output still drains normally in FAULT.
- clear: sets corr_cnt, err_cnt and the consecutive count to 0; FAULT→RUN.
  - clear has priority over an increment in the same cycle.
  - An accept in the same cycle as clear is still decoded and output, but its counts are discarded.
- Reset mid-transfer drops any pending output immediately, since reset is asynchronous.

Decomposition:
- Shared package cond_pkg:
  - the three map offsets (IF_OFS=1, CASE_OFS=3, TERN_OFS=2);
  - the state enum {RUN, FAULT};
  - a decode function that subtracts the offset mod 4.
- One combinational sub-module, cond_vote: takes the three codes and returns sel, corrected and uncorrectable.
- The top level holds the output register, handshake, counters and FSM.

Test Plan:
- Encode sel=0..3 cleanly (e.g. sel=1 → if=2, case=0, tern=3) with out_ready=1 → sel_out matches one cycle later, flags 0, counters 0.
- sel=1 with code_if=3, so d_if=2 → sel_out=1, corrected=1, corr_cnt=1.
- if=1, case=2, tern=3, so decoded values are 0/3/1 → sel_out=0, uncorrectable=1, err_cnt=1.
- Hold out_ready=0 for 4 cycles while in_valid=1 → in_ready=0, sel_out stable, exactly one symbol accepted. Then out_ready=1 → the stream resumes at 1/cycle with no loss or duplicates.
- Three consecutive uncorrectable symbols (ERR_LIMIT=3) → fault=1 and in_ready=0 after the third. Pulse clear → fault=0, counters 0, accepts resume.
- Drive 300 corrected symbols → corr_cnt saturates at 255. Assert rst_n=0 mid-stream with out_valid=1 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the condition-code decoder: encoder map offsets,
// decoder FSM states and the inverse-map helper.
package cond_pkg;

  localparam logic [1:0] IF_OFS   = 2'd1;
  localparam logic [1:0] CASE_OFS = 2'd3;
  localparam logic [1:0] TERN_OFS = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  // Inverse of an encoder map: the 2-bit subtraction wraps mod 4 by construction.
  function automatic logic [1:0] decode(input logic [1:0] code, input logic [1:0] ofs);
    return code - ofs;
  endfunction

endpackage

// File: rtl/cond_code_decoder_if.sv
// Encoder-to-decoder symbol bus plus the decoded-result and statistics outputs.
// master drives symbols and accepts results; slave is the decoder.
interface cond_code_decoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       code_if;
  logic [1:0]       code_case;
  logic [1:0]       code_tern;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       sel_out;
  logic             corrected;
  logic             uncorrectable;
  logic             fault;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             clear;

  modport master (
    output in_valid, code_if, code_case, code_tern, out_ready, clear,
    input  in_ready, out_valid, sel_out, corrected, uncorrectable, fault,
           corr_cnt, err_cnt
  );

  modport slave (
    input  in_valid, code_if, code_case, code_tern, out_ready, clear,
    output in_ready, out_valid, sel_out, corrected, uncorrectable, fault,
           corr_cnt, err_cnt
  );

endinterface

// File: rtl/cond_vote.sv
// Inverts the three encoder maps and majority-votes the recovered sel.
// Purely combinational, zero latency; no flow control.
module cond_vote
  import cond_pkg::*;
(
  input  logic [1:0] code_if,
  input  logic [1:0] code_case,
  input  logic [1:0] code_tern,
  output logic [1:0] sel,
  output logic       corrected,
  output logic       uncorrectable
);

  logic [1:0] d_if;
  logic [1:0] d_case;
  logic [1:0] d_tern;

  assign d_if   = decode(code_if, IF_OFS);
  assign d_case = decode(code_case, CASE_OFS);
  assign d_tern = decode(code_tern, TERN_OFS);

  always_comb begin
    sel           = d_if;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    if ((d_if == d_case) && (d_case == d_tern)) begin
      sel = d_if;
    end else if ((d_if == d_case) || (d_if == d_tern)) begin
      sel       = d_if;
      corrected = 1'b1;
    end else if (d_case == d_tern) begin
      sel       = d_case;
      corrected = 1'b1;
    end else begin
      // No majority: fall back to the if-map value and flag it.
      sel           = d_if;
      uncorrectable = 1'b1;
    end
  end

endmodule

// File: rtl/cond_code_decoder.sv
// Decodes redundant condition codes into sel with error statistics and fault lock-out.
// Latency 1 cycle from accept to out_valid; in_ready drops while output is stalled or in FAULT.
module cond_code_decoder
  import cond_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  cond_code_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);

  logic [1:0] vote_sel;
  logic       vote_corr;
  logic       vote_unc;

  cond_vote u_vote (
    .code_if       (bus.code_if),
    .code_case     (bus.code_case),
    .code_tern     (bus.code_tern),
    .sel           (vote_sel),
    .corrected     (vote_corr),
    .uncorrectable (vote_unc)
  );

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       sel_q, sel_d;
  logic             corr_q, corr_d;
  logic             unc_q, unc_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       consec_q, consec_d;
  logic             in_ready;
  logic             accept;

  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    corr_d      = corr_q;
    unc_d       = unc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      sel_d       = vote_sel;
      corr_d      = vote_corr;
      unc_d       = vote_unc;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // clear wins over any same-cycle increment; the accepted symbol still goes out.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    err_cnt_d  = err_cnt_q;
    consec_d   = consec_q;
    if (bus.clear) begin
      corr_cnt_d = '0;
      err_cnt_d  = '0;
      consec_d   = '0;
    end else if (accept) begin
      if (vote_corr && (corr_cnt_q != CNT_MAX)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (vote_unc && (err_cnt_q != CNT_MAX))   err_cnt_d  = err_cnt_q + 1'b1;
      consec_d = vote_unc ? (consec_q + 4'd1) : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!bus.clear && accept && vote_unc && ((consec_q + 4'd1) >= LIMIT)) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (bus.clear) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sel_q       <= 2'd0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
      corr_cnt_q  <= '0;
      err_cnt_q   <= '0;
      consec_q    <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      corr_q      <= corr_d;
      unc_q       <= unc_d;
      corr_cnt_q  <= corr_cnt_d;
      err_cnt_q   <= err_cnt_d;
      consec_q    <= consec_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.sel_out       = sel_q;
  assign bus.corrected     = corr_q;
  assign bus.uncorrectable = unc_q;
  assign bus.fault         = (state_q == FAULT);
  assign bus.corr_cnt      = corr_cnt_q;
  assign bus.err_cnt       = err_cnt_q;

endmodule
